// File: rtl/spart_echo_driver_if.sv
// Host-side SPART bus control/handshake signals (iocs/iorw/ioaddr, rda/tbr).
// The bidirectional databus is a plain inout on the driver, not part of this bundle.
interface spart_echo_driver_if;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   logic       rda;
   logic       tbr;

   modport master (output iocs, iorw, ioaddr, input rda, tbr);
   modport slave  (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_echo_driver.sv
// SPART host driver: programs the baud divisor from br_cfg, then echoes RX bytes to TX via a FIFO.
// Optional DRV_RECONFIG_EN: reprogram the divisor whenever br_cfg changes while idle.
module spart_echo_driver #(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned DIV_CFG0   = 325,
   parameter int unsigned DIV_CFG1   = 162,
   parameter int unsigned DIV_CFG2   = 81,
   parameter int unsigned DIV_CFG3   = 40,
   parameter int unsigned DIV_W      = 16,
   localparam int unsigned AW        = $clog2(FIFO_DEPTH),
   localparam int unsigned CW        = AW + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           br_cfg,
   spart_echo_driver_if.master  bus,
   inout  wire  [7:0]           databus,
   output logic [CW-1:0]        fifo_count,
   output logic                 overflow,
   output logic                 cfg_done
);

   typedef enum logic [2:0] {CFG_LO, CFG_HI, IDLE, RD, WR} state_t;

   state_t          state;
   logic            iocs_q, iorw_q;
   logic [1:0]      ioaddr_q;
   logic [7:0]      dout;
   logic [7:0]      div_hi;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;
   logic            full, empty;
   logic [1:0]      br_new;
   logic [15:0]     div_new;
   logic            reconfig;

   function automatic logic [15:0] div_sel(input logic [1:0] sel);
      logic [15:0] d;
      d = '0;
      case (sel)
         2'b00:   d[DIV_W-1:0] = DIV_CFG0[DIV_W-1:0];
         2'b01:   d[DIV_W-1:0] = DIV_CFG1[DIV_W-1:0];
         2'b10:   d[DIV_W-1:0] = DIV_CFG2[DIV_W-1:0];
         default: d[DIV_W-1:0] = DIV_CFG3[DIV_W-1:0];
      endcase
      return d;
   endfunction

   assign full       = (count == CW'(FIFO_DEPTH));
   assign empty      = (count == '0);
   assign fifo_count = count;

`ifdef DRV_RECONFIG_EN
   logic [1:0] br_q, cfg_sel;

   // br_q is a one-cycle registered copy; cfg_sel is the selection currently programmed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         br_q    <= 2'b00;
         cfg_sel <= 2'b00;
      end else begin
         br_q <= br_cfg;
         if (state == CFG_LO && !iocs_q)
            cfg_sel <= br_cfg;
         else if (state == IDLE && reconfig)
            cfg_sel <= br_q;
      end
   end

   assign reconfig = (br_q != cfg_sel);
   assign br_new   = (state == IDLE) ? br_q : br_cfg;
`else
   assign reconfig = 1'b0;
   assign br_new   = br_cfg;
`endif

   assign div_new = div_sel(br_new);

   // CFG_LO with iocs low is the post-reset pre-phase; the first edge puts DB_LOW on the bus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= CFG_LO;
         iocs_q   <= 1'b0;
         iorw_q   <= 1'b1;
         ioaddr_q <= 2'b00;
         dout     <= 8'h00;
         div_hi   <= 8'h00;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         cfg_done <= 1'b0;
      end else begin
         case (state)
            CFG_LO: begin
               if (!iocs_q) begin
                  iocs_q   <= 1'b1;
                  iorw_q   <= 1'b0;
                  ioaddr_q <= 2'b10;
                  dout     <= div_new[7:0];
                  div_hi   <= div_new[15:8];
               end else begin
                  state    <= CFG_HI;
                  ioaddr_q <= 2'b11;
                  dout     <= div_hi;
               end
            end
            CFG_HI: begin
               state    <= IDLE;
               iocs_q   <= 1'b0;
               iorw_q   <= 1'b1;
               ioaddr_q <= 2'b00;
               cfg_done <= 1'b1;
            end
            IDLE: begin
               if (reconfig) begin
                  state    <= CFG_LO;
                  iocs_q   <= 1'b1;
                  iorw_q   <= 1'b0;
                  ioaddr_q <= 2'b10;
                  dout     <= div_new[7:0];
                  div_hi   <= div_new[15:8];
                  cfg_done <= 1'b0;
               end else if (bus.rda) begin
                  state    <= RD;
                  iocs_q   <= 1'b1;
                  iorw_q   <= 1'b1;
                  ioaddr_q <= 2'b00;
               end else if (bus.tbr && !empty) begin
                  state    <= WR;
                  iocs_q   <= 1'b1;
                  iorw_q   <= 1'b0;
                  ioaddr_q <= 2'b00;
                  dout     <= mem[rd_ptr];
               end
            end
            RD: begin
               state  <= IDLE;
               iocs_q <= 1'b0;
               iorw_q <= 1'b1;
               if (!full) begin
                  wr_ptr <= wr_ptr + 1'b1;
                  count  <= count + 1'b1;
               end else begin
                  overflow <= 1'b1;
               end
            end
            WR: begin
               state  <= IDLE;
               iocs_q <= 1'b0;
               iorw_q <= 1'b1;
               rd_ptr <= rd_ptr + 1'b1;
               count  <= count - 1'b1;
            end
            default: state <= CFG_LO;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == RD && !full)
         mem[wr_ptr] <= databus;
   end

   assign bus.iocs   = iocs_q;
   assign bus.iorw   = iorw_q;
   assign bus.ioaddr = ioaddr_q;
   assign databus    = (iocs_q && !iorw_q) ? dout : 8'hzz;

endmodule
